e_mdu: RTL
==========

// Module: e_mdu
// PURPOSE
//   Multiply/divide unit in the E stage of the 5-stage MIPS pipeline, downstream of D.
//   Receives MDUStart/op and forwarded rs/rt operands from the D/E register.
//   Runs a fixed-latency busy window and commits to architectural HI/LO.
//   Exposes Busy and Start so D-stage hazard logic stalls any MDUClass instruction.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (and madd family); must be >=1
//   DIV_CYCLES   10  busy cycles for div/divu; must be >=1
// PORTS
//   clk     in   1   pipeline clock, rising edge
//   reset   in   1   asynchronous, active-high; clears all state
//   Start   in   1   E-stage instr is a busy-type MDU op (mult/div family)
//   MDUOp   in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                    7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 = none
//   A       in   32  rs operand, post-forwarding
//   B       in   32  rt operand, post-forwarding
//   Busy    out  1   operation in flight
//   HI      out  32  architectural HI, read by mfhi
//   LO      out  32  architectural LO, read by mflo
// BEHAVIOUR
//   - Reset (any time, incl. mid-op): Busy=0, HI=0, LO=0, counter=0; in-flight result dropped.
//   - FSM IDLE/BUSY. IDLE + Start + busy-type op at edge t: result computed from A/B,
//     latched to shadow regs, counter loaded with N-1, Busy=1 from edge t
//     (N = MULT_CYCLES or DIV_CYCLES).
//   - BUSY: counter decrements each edge. At the edge with counter==0, shadow commits
//     to HI/LO and Busy=0 on that same edge. Busy is high for exactly N cycles.
//   - HI/LO keep old values during BUSY. Commit is atomic: no partial update visible.
//   - Start or MDUOp 5/6 while BUSY: ignored (D stalls this by contract; bench asserts).
//     Start with non-busy op (0,5,6,11-15): no busy window.
//   - mthi/mtlo (Start=0, op 5/6) in IDLE: HI<=A or LO<=A at the next edge. Single cycle,
//     Busy stays 0.
//   - mult: {HI,LO} = signed A*B (64b). multu: unsigned.
//   - div: LO = quotient truncated toward zero, HI = remainder with the sign of A.
//     divu: unsigned.
//   - Divide by zero: full busy window runs, HI/LO unchanged at commit.
//   - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//   - Busy-type Start and mthi/mtlo in the same cycle is impossible (one op per instr).
//   - No flush input: an op in E is architecturally committed.
// CONFIGURATION
//   MDU_MADD_EN defined: ops 7-10 valid. madd/maddu: {HI,LO} += A*B (signed/unsigned).
//     msub/msubu: {HI,LO} -= A*B. Base value is {HI,LO} at Start. MULT_CYCLES latency.
//     Mod 2^64 wrap.
//   MDU_MADD_EN undefined: ops 7-10 treated as none. No busy window, HI/LO unchanged,
//     no accumulator logic synthesized.
// TESTING
//   1. Reset asserted mid-div (3rd busy cycle) -> Busy, HI, LO = 0 immediately;
//      no commit after release.
//   2. mult A=0xFFFFFFFF B=2 -> Busy 5 cycles, HI=0xFFFFFFFF LO=0xFFFFFFFE.
//      multu same operands -> HI=0x00000001 LO=0xFFFFFFFE.
//   3. div A=0xFFFFFFF9 (-7) B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      divu A=7 B=0 -> HI/LO unchanged, Busy still 10 cycles.
//   4. mthi A=0x12345678 then mtlo A=0x9 on consecutive cycles -> HI=0x12345678, LO=0x9.
//      Busy never rises.
//   5. mult 3*4 issued; mthi forced during BUSY -> ignored, assertion fires.
//      HI/LO hold old values until commit, then HI=0 LO=0xC.
//   6. MDU_MADD_EN: HI=0 LO=0xFFFFFFFF, maddu A=1 B=1 -> HI=1 LO=0.
//      Without macro, op 8 -> no change, Busy 0.

Source files
------------

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency busy window, atomic HI/LO commit.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 7-10) with HI/LO accumulation.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   shi_q, shi_d, slo_q, slo_d;

  logic          is_mul, is_div;
  logic [63:0]   prod_s, prod_u;
`ifdef MDU_MADD_EN
  logic [63:0]   acc;
  assign acc = {hi_q, lo_q};
`endif

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  always_comb begin
    is_mul = (MDUOp == 4'd1) || (MDUOp == 4'd2);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (MDUOp >= 4'd7 && MDUOp <= 4'd10);
`endif
    is_div = (MDUOp == 4'd3) || (MDUOp == 4'd4);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start && (is_mul || is_div)) begin
          state_d = S_BUSY;
          cnt_d   = is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
          // Divide by zero commits the current HI/LO back, i.e. no visible change.
          shi_d   = hi_q;
          slo_d   = lo_q;
          case (MDUOp)
            4'd1: {shi_d, slo_d} = prod_s;
            4'd2: {shi_d, slo_d} = prod_u;
            4'd3: begin
              if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                slo_d = 32'h8000_0000;
                shi_d = 32'd0;
              end else if (B != 32'd0) begin
                slo_d = $signed(A) / $signed(B);
                shi_d = $signed(A) % $signed(B);
              end
            end
            4'd4: begin
              if (B != 32'd0) begin
                slo_d = A / B;
                shi_d = A % B;
              end
            end
`ifdef MDU_MADD_EN
            4'd7:  {shi_d, slo_d} = acc + prod_s;
            4'd8:  {shi_d, slo_d} = acc + prod_u;
            4'd9:  {shi_d, slo_d} = acc - prod_s;
            4'd10: {shi_d, slo_d} = acc - prod_u;
`endif
            default: ;
          endcase
        end else if (MDUOp == 4'd5) begin
          hi_d = A;
        end else if (MDUOp == 4'd6) begin
          lo_d = A;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          hi_d    = shi_q;
          lo_d    = slo_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
    end
  end

  assign Busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
